// File: rtl/traffic_conflict_monitor.sv
// Watches the NS/EW signal-head aspects and latches the first safety violation it sees.
// A latched fault commands an all-red flash until it is cleared or reset.
module traffic_conflict_monitor #(
    parameter int MIN_GREEN  = 40,
    parameter int MIN_YELLOW = 8,
    parameter int MAX_PHASE  = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  ns_light,
    input  logic [2:0]  ew_light,
    input  logic        clear_fault,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic        flash_red,
    output logic [15:0] cycle_cnt
);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef enum logic [1:0] {
        ARMING  = 2'd0,
        MONITOR = 2'd1,
        FAULT   = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  cur [2];
    logic [2:0]  prev_reg [2];
    logic [2:0]  prev_next [2];
    logic [15:0] dwell_reg [2];
    logic [15:0] dwell_next [2];
    logic [15:0] dwell_inc [2];
    logic [1:0]  valid_reg, valid_next;
    logic [15:0] wd_reg, wd_next, wd_inc;
    logic [15:0] cycle_reg, cycle_next;
    logic        fault_reg, fault_next;
    logic [2:0]  code_reg, code_next, viol_code;
    logic [1:0]  onehot, changed, trans_ok, yel_short, grn_short;
    logic        wd_expired, ns_r2g;

    assign cur[0] = ns_light;
    assign cur[1] = ew_light;

    // Index 0 is north-south, index 1 is east-west.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dir
            assign onehot[gi]    = (cur[gi] == RED) || (cur[gi] == YEL) || (cur[gi] == GRN);
            assign changed[gi]   = (cur[gi] != prev_reg[gi]);
            assign trans_ok[gi]  = !changed[gi]
                                || ((prev_reg[gi] == GRN) && (cur[gi] == YEL))
                                || ((prev_reg[gi] == YEL) && (cur[gi] == RED))
                                || ((prev_reg[gi] == RED) && (cur[gi] == GRN));
            // dwell_reg still holds the length of the phase that is ending.
            assign yel_short[gi] = valid_reg[gi] && (prev_reg[gi] == YEL) && (cur[gi] == RED)
                                && (dwell_reg[gi] < 16'(MIN_YELLOW));
            assign grn_short[gi] = valid_reg[gi] && (prev_reg[gi] == GRN) && (cur[gi] == YEL)
                                && (dwell_reg[gi] < 16'(MIN_GREEN));
            assign dwell_inc[gi] = changed[gi] ? 16'd1
                                 : ((dwell_reg[gi] == 16'hFFFF) ? dwell_reg[gi] : dwell_reg[gi] + 16'd1);
        end
    endgenerate

    assign wd_inc     = (|changed) ? 16'd1 : ((wd_reg == 16'hFFFF) ? wd_reg : wd_reg + 16'd1);
    assign wd_expired = (wd_inc >= 16'(MAX_PHASE));
    assign ns_r2g     = (prev_reg[0] == RED) && (cur[0] == GRN);

    // Lowest-numbered cause wins when several rules fire on the same sample.
    always_comb begin
        viol_code = 3'd0;
        if (!(&onehot))
            viol_code = 3'd1;
        else if ((cur[0] != RED) && (cur[1] != RED))
            viol_code = 3'd2;
        else if (!(&trans_ok))
            viol_code = 3'd3;
        else if (|yel_short)
            viol_code = 3'd4;
        else if (|grn_short)
            viol_code = 3'd5;
        else if (wd_expired)
            viol_code = 3'd6;
    end

    always_comb begin
        state_next = state_reg;
        prev_next  = prev_reg;
        dwell_next = dwell_reg;
        valid_next = valid_reg;
        wd_next    = wd_reg;
        cycle_next = cycle_reg;
        fault_next = fault_reg;
        code_next  = code_reg;
        case (state_reg)
            ARMING: begin
                if (&onehot) begin
                    state_next = MONITOR;
                    prev_next  = cur;
                    valid_next = 2'b00;
                    wd_next    = 16'd1;
                    for (int i = 0; i < 2; i++)
                        dwell_next[i] = 16'd1;
                end
            end
            MONITOR: begin
                if (viol_code != 3'd0) begin
                    state_next = FAULT;
                    fault_next = 1'b1;
                    code_next  = viol_code;
                end else begin
                    prev_next  = cur;
                    dwell_next = dwell_inc;
                    valid_next = valid_reg | changed;
                    wd_next    = wd_inc;
                    if (ns_r2g)
                        cycle_next = cycle_reg + 16'd1;
                end
            end
            FAULT: begin
                if (clear_fault) begin
                    state_next = ARMING;
                    fault_next = 1'b0;
                    code_next  = 3'd0;
                end
            end
            default: state_next = ARMING;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ARMING;
            valid_reg <= 2'b00;
            wd_reg    <= 16'd0;
            cycle_reg <= 16'd0;
            fault_reg <= 1'b0;
            code_reg  <= 3'd0;
            for (int i = 0; i < 2; i++) begin
                prev_reg[i]  <= 3'b000;
                dwell_reg[i] <= 16'd0;
            end
        end else begin
            state_reg <= state_next;
            prev_reg  <= prev_next;
            dwell_reg <= dwell_next;
            valid_reg <= valid_next;
            wd_reg    <= wd_next;
            cycle_reg <= cycle_next;
            fault_reg <= fault_next;
            code_reg  <= code_next;
        end
    end

    assign fault      = fault_reg;
    assign flash_red  = fault_reg;
    assign fault_code = code_reg;
    assign cycle_cnt  = cycle_reg;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: fixed vector table, directed corner sequences,
// then random aspect streams compared against a rule-level reference model.
module tb_traffic_conflict_monitor;

    localparam int MIN_GREEN  = 40;
    localparam int MIN_YELLOW = 8;
    localparam int MAX_PHASE  = 200;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  ns_light = 3'b000;
    logic [2:0]  ew_light = 3'b000;
    logic        clear_fault = 1'b0;
    logic        fault;
    logic [2:0]  fault_code;
    logic        flash_red;
    logic [15:0] cycle_cnt;

    traffic_conflict_monitor #(
        .MIN_GREEN (MIN_GREEN),
        .MIN_YELLOW(MIN_YELLOW),
        .MAX_PHASE (MAX_PHASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .clear_fault(clear_fault),
        .fault      (fault),
        .fault_code (fault_code),
        .flash_red  (flash_red),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference model: mode 0 = arming, 1 = monitoring, 2 = faulted.
    int          m_mode;
    int          m_code;
    int          m_cycles;
    int          m_pair_run;
    logic [2:0]  m_prev [2];
    int          m_run [2];
    bit          m_seen [2];

    function automatic bit legal(input logic [2:0] x);
        return (x === G) || (x === Y) || (x === R);
    endfunction

    function automatic logic [2:0] successor(input logic [2:0] x);
        if (x == G) return Y;
        if (x == Y) return R;
        return G;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_code = 0; m_cycles = 0; m_pair_run = 0;
        for (int d = 0; d < 2; d++) begin
            m_prev[d] = 3'b000; m_run[d] = 0; m_seen[d] = 0;
        end
    endtask

    task automatic model_step(input logic [2:0] ns, input logic [2:0] ew, input logic clr);
        logic [2:0] cur [2];
        int v [$];
        int best;
        cur[0] = ns;
        cur[1] = ew;
        if (m_mode == 0) begin
            if (legal(ns) && legal(ew)) begin
                m_mode = 1;
                m_pair_run = 1;
                for (int d = 0; d < 2; d++) begin
                    m_prev[d] = cur[d]; m_run[d] = 1; m_seen[d] = 0;
                end
            end
        end else if (m_mode == 1) begin
            if (!legal(ns) || !legal(ew)) v.push_back(1);
            if (ns != R && ew != R) v.push_back(2);
            for (int d = 0; d < 2; d++) begin
                if (cur[d] != m_prev[d] && cur[d] != successor(m_prev[d])) v.push_back(3);
                if (m_seen[d] && m_prev[d] == Y && cur[d] == R && m_run[d] < MIN_YELLOW) v.push_back(4);
                if (m_seen[d] && m_prev[d] == G && cur[d] == Y && m_run[d] < MIN_GREEN) v.push_back(5);
            end
            if (cur[0] == m_prev[0] && cur[1] == m_prev[1] && m_pair_run + 1 >= MAX_PHASE) v.push_back(6);
            if (v.size() > 0) begin
                best = 7;
                foreach (v[k]) if (v[k] < best) best = v[k];
                m_mode = 2;
                m_code = best;
            end else begin
                if (m_prev[0] == R && cur[0] == G) m_cycles = (m_cycles + 1) % 65536;
                m_pair_run = (cur[0] == m_prev[0] && cur[1] == m_prev[1]) ? m_pair_run + 1 : 1;
                for (int d = 0; d < 2; d++) begin
                    if (cur[d] != m_prev[d]) begin
                        m_run[d] = 1; m_seen[d] = 1;
                    end else if (m_run[d] < 65535) begin
                        m_run[d]++;
                    end
                    m_prev[d] = cur[d];
                end
            end
        end else if (clr) begin
            m_mode = 0;
            m_code = 0;
        end
    endtask

    task automatic do_cycle(input logic [2:0] ns, input logic [2:0] ew, input logic clr, input string tag);
        ns_light = ns; ew_light = ew; clear_fault = clr;
        @(posedge clk);
        #1;
        model_step(ns, ew, clr);
        check({tag, ".fault"}, 32'(fault), 32'(m_mode == 2));
        check({tag, ".flash_red"}, 32'(flash_red), 32'(m_mode == 2));
        check({tag, ".fault_code"}, 32'(fault_code), 32'(m_code));
        check({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'(m_cycles));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".fault"}, 32'(fault), 0);
        check({tag, ".flash_red"}, 32'(flash_red), 0);
        check({tag, ".fault_code"}, 32'(fault_code), 0);
        check({tag, ".cycle_cnt"}, 32'(cycle_cnt), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One full signal cycle is 124 samples: NS G51/Y11/R62 against EW R62/G51/Y11.
    task automatic run_pattern(input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            for (int t = 0; t < 124; t++) begin
                if (t < 51)       do_cycle(G, R, 1'b0, tag);
                else if (t < 62)  do_cycle(Y, R, 1'b0, tag);
                else if (t < 113) do_cycle(R, G, 1'b0, tag);
                else              do_cycle(R, Y, 1'b0, tag);
            end
        end
    endtask

    function automatic int pick_len(input int p);
        if (p % 2 == 1) return int'($urandom_range(MIN_YELLOW - 2, MIN_YELLOW + 4));
        if ($urandom_range(0, 15) == 0) return int'($urandom_range(195, 205));
        return int'($urandom_range(MIN_GREEN - 2, MIN_GREEN + 6));
    endfunction

    typedef struct {
        logic [2:0]  ns;
        logic [2:0]  ew;
        logic        clr;
        logic        exp_fault;
        logic [2:0]  exp_code;
        logic [15:0] exp_cycle;
    } vec_t;

    vec_t tbl [22];

    initial begin
        logic [2:0] a, b;
        logic       c;
        int         ph, left;

        tbl[0]  = '{3'b000, 3'b000, 1'b0, 1'b0, 3'd0, 16'd0};
        tbl[1]  = '{3'b000, 3'b000, 1'b0, 1'b0, 3'd0, 16'd0};
        tbl[2]  = '{3'b011, R,      1'b0, 1'b0, 3'd0, 16'd0};
        tbl[3]  = '{G,      R,      1'b0, 1'b0, 3'd0, 16'd0};
        tbl[4]  = '{G,      R,      1'b1, 1'b0, 3'd0, 16'd0};
        tbl[5]  = '{G,      G,      1'b0, 1'b1, 3'd2, 16'd0};
        tbl[6]  = '{R,      R,      1'b0, 1'b1, 3'd2, 16'd0};
        tbl[7]  = '{3'b011, G,      1'b0, 1'b1, 3'd2, 16'd0};
        tbl[8]  = '{G,      R,      1'b1, 1'b0, 3'd0, 16'd0};
        tbl[9]  = '{G,      R,      1'b0, 1'b0, 3'd0, 16'd0};
        tbl[10] = '{R,      R,      1'b0, 1'b1, 3'd3, 16'd0};
        tbl[11] = '{R,      R,      1'b1, 1'b0, 3'd0, 16'd0};
        tbl[12] = '{R,      R,      1'b0, 1'b0, 3'd0, 16'd0};
        tbl[13] = '{3'b011, G,      1'b0, 1'b1, 3'd1, 16'd0};
        tbl[14] = '{R,      R,      1'b1, 1'b0, 3'd0, 16'd0};
        tbl[15] = '{Y,      R,      1'b0, 1'b0, 3'd0, 16'd0};
        tbl[16] = '{R,      R,      1'b0, 1'b0, 3'd0, 16'd0};
        tbl[17] = '{G,      R,      1'b0, 1'b0, 3'd0, 16'd1};
        tbl[18] = '{Y,      R,      1'b0, 1'b1, 3'd5, 16'd1};
        tbl[19] = '{Y,      R,      1'b1, 1'b0, 3'd0, 16'd1};
        tbl[20] = '{Y,      R,      1'b0, 1'b0, 3'd0, 16'd1};
        tbl[21] = '{G,      R,      1'b0, 1'b1, 3'd3, 16'd1};

        #2;
        do_reset();

        foreach (tbl[i]) begin
            ns_light = tbl[i].ns; ew_light = tbl[i].ew; clear_fault = tbl[i].clr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.fault", i), 32'(fault), 32'(tbl[i].exp_fault));
            check($sformatf("vec%0d.flash_red", i), 32'(flash_red), 32'(tbl[i].exp_fault));
            check($sformatf("vec%0d.fault_code", i), 32'(fault_code), 32'(tbl[i].exp_code));
            check($sformatf("vec%0d.cycle_cnt", i), 32'(cycle_cnt), 32'(tbl[i].exp_cycle));
            $display("vec %0d ns=%b ew=%b clr=%b -> fault=%b code=%0d cycles=%0d",
                     i, tbl[i].ns, tbl[i].ew, tbl[i].clr, fault, fault_code, cycle_cnt);
        end

        // Three clean signal cycles, then short green and short yellow.
        do_reset();
        run_pattern(3, "clean");
        check("clean.cycle_cnt_const", 32'(cycle_cnt), 2);
        $display("clean pattern x3: fault=%b cycles=%0d", fault, cycle_cnt);
        for (int t = 0; t < 30; t++) do_cycle(G, R, 1'b0, "short_green");
        do_cycle(Y, R, 1'b0, "short_green");
        check("short_green.code_const", 32'(fault_code), 5);
        $display("short green: fault=%b code=%0d", fault, fault_code);
        do_cycle(Y, R, 1'b1, "clear");
        run_pattern(1, "rearm");
        for (int t = 0; t < 51; t++) do_cycle(G, R, 1'b0, "short_yellow");
        for (int t = 0; t < 5; t++)  do_cycle(Y, R, 1'b0, "short_yellow");
        do_cycle(R, R, 1'b0, "short_yellow");
        check("short_yellow.code_const", 32'(fault_code), 4);
        $display("short yellow: fault=%b code=%0d", fault, fault_code);

        // Watchdog on a frozen pair, counted from the arming sample.
        do_cycle(G, R, 1'b1, "clear");
        for (int s = 1; s <= 199; s++) do_cycle(G, R, 1'b0, "frozen");
        check("frozen.199_fault_const", 32'(fault), 0);
        do_cycle(G, R, 1'b0, "frozen");
        check("frozen.200_code_const", 32'(fault_code), 6);
        $display("frozen pair 200 samples: fault=%b code=%0d", fault, fault_code);
        do_cycle(G, R, 1'b1, "clear");
        do_cycle(G, R, 1'b0, "rearm");
        do_cycle(G, R, 1'b0, "rearm");
        check("rearm.fault_const", 32'(fault), 0);

        // Asynchronous reset from FAULT with a non-zero cycle count.
        do_reset();
        run_pattern(6, "six_cycles");
        do_cycle(G, G, 1'b0, "conflict");
        check("conflict.code_const", 32'(fault_code), 2);
        check("conflict.cycle_const", 32'(cycle_cnt), 5);
        for (int t = 0; t < 3; t++) do_cycle(G, R, 1'b0, "conflict_hold");
        check("conflict_hold.flash_const", 32'(flash_red), 1);
        $display("conflict: fault=%b code=%0d cycles=%0d", fault, fault_code, cycle_cnt);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_zero("async_reset");
        $display("async reset in fault: fault=%b code=%0d cycles=%0d", fault, fault_code, cycle_cnt);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int t = 0; t < 3; t++) do_cycle(3'b000, 3'b000, 1'b0, "post_reset_zero");

        // Random aspect streams, mostly well-formed with boundary dwells and glitches.
        do_reset();
        ph = 3;
        left = 0;
        for (int i = 0; i < 6000; i++) begin
            if (left == 0) begin
                if ($urandom_range(0, 39) == 0) ph = int'($urandom_range(0, 3));
                else ph = (ph + 1) % 4;
                left = pick_len(ph);
            end
            case (ph)
                0:       begin a = G; b = R; end
                1:       begin a = Y; b = R; end
                2:       begin a = R; b = G; end
                default: begin a = R; b = Y; end
            endcase
            if ($urandom_range(0, 49) == 0) begin
                a = 3'($urandom_range(0, 7));
                b = 3'($urandom_range(0, 7));
            end
            c = ($urandom_range(0, 29) == 0) || (m_mode == 2 && $urandom_range(0, 7) == 0);
            do_cycle(a, b, c, "random");
            left--;
            if (i % 1000 == 999)
                $display("random block %0d: fault=%b code=%0d cycles=%0d", i / 1000, fault, fault_code, cycle_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
